gpi: RTL



---
 rtl/gpi_pkg.sv | 16 +
 rtl/gpi_debounce.sv | 83 ++++++++
 rtl/gpi.sv | 132 +++++++++++++
 3 files changed

// File: rtl/gpi_pkg.sv
// -----------------------------------------------------------------------------
// gpi_pkg
// Register index constants for the general-purpose input slave. Firmware
// header generation and the testbench use these same values.
// -----------------------------------------------------------------------------
package gpi_pkg;

   // Word register indices on the slave's addr bus
   localparam logic [1:0] GPI_IDR       = 2'd0;  // debounced pin state (RO)
   localparam logic [1:0] GPI_RISE_EN   = 2'd1;  // rising-edge flag enables
   localparam logic [1:0] GPI_FALL_EN   = 2'd2;  // falling-edge flag enables
   localparam logic [1:0] GPI_EDGE_FLAG = 2'd3;  // sticky edge flags (W1C)

   localparam int GPI_BUS_W = 32;

endpackage

// File: rtl/gpi_debounce.sv
// -----------------------------------------------------------------------------
// gpi_debounce
// One input bit: two-flop synchronizer followed by a debounce counter. The
// debounced state only follows the synchronized level after it has differed
// from it on DB_CYCLES consecutive clocks. rise_o/fall_o are combinational and
// high during the cycle whose closing edge updates db_o, so the parent can
// register an edge flag on the very edge that the new level is accepted.
//
// Ports
//   clk     system clock
//   reset   asynchronous active-high reset
//   pin_i   raw asynchronous pin
//   db_o    debounced level
//   rise_o  db_o is about to change 0->1 on the next edge
//   fall_o  db_o is about to change 1->0 on the next edge
// -----------------------------------------------------------------------------
module gpi_debounce #(
   parameter int DB_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic pin_i,
   output logic db_o,
   output logic rise_o,
   output logic fall_o
);

   // Sized to hold DB_CYCLES; the count is cleared at acceptance so it never wraps
   localparam int               CNT_W    = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             db_q;
   logic             db_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             accept;

   // Synchronizer stage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= pin_i;
         sync2_q <= sync1_q;
      end
   end

   // Any return to equality restarts the count, so short pulses never reach
   // CNT_LAST and are rejected.
   always_comb begin
      accept = 1'b0;
      db_d   = db_q;
      cnt_d  = cnt_q;
      if (sync2_q == db_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         accept = 1'b1;
         db_d   = sync2_q;
         cnt_d  = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Debounce state stage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         db_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         db_q  <= db_d;
         cnt_q <= cnt_d;
      end
   end

   assign db_o   = db_q;
   assign rise_o = accept &  sync2_q;
   assign fall_o = accept & ~sync2_q;

endmodule

// File: rtl/gpi.sv
// -----------------------------------------------------------------------------
// gpi
// Memory-mapped general-purpose input slave. Each of WIDTH pins is
// synchronized and debounced; accepted rising/falling transitions set sticky
// write-1-to-clear flags when enabled, and irq is high while any flag is set.
//
// Register map (word index on addr)
//   0 IDR        debounced pin state, read-only (writes ignored)
//   1 RISE_EN    R/W, one enable per pin
//   2 FALL_EN    R/W, one enable per pin
//   3 EDGE_FLAG  read flags; write 1 to clear a bit
//   Bits above WIDTH read as 0.
//
// Ports
//   clk     system clock
//   reset   asynchronous active-high reset
//   ce      chip enable from the bus interconnect
//   wr_en   write strobe, qualified by ce
//   addr    word register index
//   wdata   write data
//   rdata   combinational read data of the addressed register (ignores ce)
//   inPort  asynchronous external pins
//   irq     registered OR of the edge flags
// -----------------------------------------------------------------------------
module gpi
   import gpi_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int DB_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ce,
   input  logic             wr_en,
   input  logic [1:0]       addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   input  logic [WIDTH-1:0] inPort,
   output logic             irq
);

   localparam logic [31:0] WMASK = 32'hFFFF_FFFF >> (GPI_BUS_W - WIDTH);

   logic [WIDTH-1:0] db;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;

   logic [WIDTH-1:0] rise_en_q;
   logic [WIDTH-1:0] rise_en_d;
   logic [WIDTH-1:0] fall_en_q;
   logic [WIDTH-1:0] fall_en_d;
   logic [WIDTH-1:0] flag_q;
   logic [WIDTH-1:0] flag_d;
   logic             irq_q;
   logic             irq_d;

   logic             bus_wr;
   logic [WIDTH-1:0] flag_set;
   logic [WIDTH-1:0] flag_clr;
   logic             unused_wdata_hi;

   // Per-pin synchronize + debounce
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      gpi_debounce #(
         .DB_CYCLES (DB_CYCLES)
      ) u_debounce (
         .clk    (clk),
         .reset  (reset),
         .pin_i  (inPort[i]),
         .db_o   (db[i]),
         .rise_o (rise[i]),
         .fall_o (fall[i])
      );
   end

   assign bus_wr          = ce & wr_en;
   assign unused_wdata_hi = |(wdata & ~WMASK);

   // Next-state for the register file. Enables are sampled at their current
   // value, so reprogramming them never creates or removes a flag by itself.
   // The set term is OR-ed in after the clear, so a simultaneous event wins
   // over a W1C write on the same bit.
   always_comb begin
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      flag_clr  = '0;

      if (bus_wr) begin
         case (addr)
            GPI_RISE_EN:   rise_en_d = wdata[WIDTH-1:0];
            GPI_FALL_EN:   fall_en_d = wdata[WIDTH-1:0];
            GPI_EDGE_FLAG: flag_clr  = wdata[WIDTH-1:0];
            default:       ;
         endcase
      end

      flag_set = (rise & rise_en_q) | (fall & fall_en_q);
      flag_d   = (flag_q & ~flag_clr) | flag_set;
      // irq tracks the flag register as it will be after this edge
      irq_d    = |flag_d;
   end

   // Register file stage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rise_en_q <= '0;
         fall_en_q <= '0;
         flag_q    <= '0;
         irq_q     <= 1'b0;
      end else begin
         rise_en_q <= rise_en_d;
         fall_en_q <= fall_en_d;
         flag_q    <= flag_d;
         irq_q     <= irq_d;
      end
   end

   // Zero-wait-state read path, zero-extended to the bus width
   always_comb begin
      rdata = '0;
      case (addr)
         GPI_IDR:       rdata[WIDTH-1:0] = db;
         GPI_RISE_EN:   rdata[WIDTH-1:0] = rise_en_q;
         GPI_FALL_EN:   rdata[WIDTH-1:0] = fall_en_q;
         GPI_EDGE_FLAG: rdata[WIDTH-1:0] = flag_q;
         default:       ;
      endcase
   end

   assign irq = irq_q;

endmodule
